// File: rtl/rgb_proto_pkg.sv
// Shared definitions for the RGB frame consumer: command codes, the
// maximum payload length, FSM state encodings and the frame validation
// helpers used in the CHECK state.
package rgb_proto_pkg;

   localparam logic [7:0] CMD_SET = 8'h01;
   localparam logic [7:0] CMD_OFF = 8'h02;
   localparam logic [7:0] MAX_LEN = 8'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_APPLY  = 2'd2,
      ST_REJECT = 2'd3
   } state_e;

   // XOR over the bytes actually carried by the frame; g and b only
   // contribute when the length says they are present.
   function automatic logic [7:0] frame_sum(
      input logic [7:0] cmd,
      input logic [7:0] len,
      input logic [7:0] r,
      input logic [7:0] g,
      input logic [7:0] b
   );
      logic [7:0] s;
      s = cmd ^ len ^ r;
      if (len >= 8'd2)    s = s ^ g;
      if (len == MAX_LEN) s = s ^ b;
      return s;
   endfunction

   function automatic logic frame_bad(
      input logic [7:0] cmd,
      input logic [7:0] len,
      input logic [7:0] r,
      input logic [7:0] g,
      input logic [7:0] b,
      input logic [7:0] chk
   );
      logic bad_len;
      logic bad_sum;
      logic bad_cmd;
      bad_len = (len == 8'd0) || (len > MAX_LEN);
      bad_sum = (frame_sum(cmd, len, r, g, b) != chk);
      bad_cmd = (cmd != CMD_SET) && (cmd != CMD_OFF);
      return bad_len || bad_sum || bad_cmd;
   endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM colour channel.
//   clk, reset : system clock, synchronous active-low reset
//   pend       : pending duty, copied into the live duty when load is high
//   load       : period-aligned load strobe (pwm_cnt wrapping 255->0)
//   cnt        : shared free-running PWM counter
//   en         : LED enable; gates the output immediately
//   pwm        : registered PWM output, polarity set by INVERT_OUT
module rgb_pwm_channel #(
   parameter bit INVERT_OUT = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pend,
   input  logic       load,
   input  logic [7:0] cnt,
   input  logic       en,
   output logic       pwm
);

   logic [7:0] duty_q, duty_d;
   logic       pwm_q, pwm_d;

   always_comb begin
      duty_d = load ? pend : duty_q;
      pwm_d  = (en && (cnt < duty_q)) ^ INVERT_OUT;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         duty_q <= 8'd0;
         pwm_q  <= INVERT_OUT;
      end else begin
         duty_q <= duty_d;
         pwm_q  <= pwm_d;
      end
   end

   assign pwm = pwm_q;

endmodule

// File: rtl/rgb_frame_pwm.sv
// Frame consumer and three-channel PWM driver for the RGB LED.
// Takes decoded frames from the serial receiver, validates length,
// command and XOR check byte, updates pending duties / LED enable and
// drives pwm_r/g/b. Rejected frames bump a saturating error counter.
//   clk, reset            : system clock, synchronous active-low reset
//   frame_valid           : one-cycle frame strobe, bytes valid that cycle
//   cmd_in .. check_in    : frame bytes
//   pwm_r, pwm_g, pwm_b   : PWM outputs
//   frame_ok, frame_err   : one-cycle accept / reject pulses
//   err_count             : rejected frames, saturating at 255
//   state                 : FSM state for debug
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE   0  | waiting for frame_valid; latches frame bytes
// CHECK  1  | validates length, command and check byte
// APPLY  2  | frame_ok pulse; updates pend_* / led_en
// REJECT 3  | frame_err pulse; bumps err_count
module rgb_frame_pwm
   import rgb_proto_pkg::*;
#(
   parameter int unsigned PRESCALE   = 4,
   parameter bit          INVERT_OUT = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_valid,
   input  logic [7:0] cmd_in,
   input  logic [7:0] length_in,
   input  logic [7:0] r_in,
   input  logic [7:0] g_in,
   input  logic [7:0] b_in,
   input  logic [7:0] check_in,
   output logic       pwm_r,
   output logic       pwm_g,
   output logic       pwm_b,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [7:0] err_count,
   output logic [1:0] state
);

   localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   state_e     state_q, state_d;
   logic [7:0] cmd_q, cmd_d, len_q, len_d, chk_q, chk_d;
   logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic [7:0] pend_r_q, pend_r_d, pend_g_q, pend_g_d, pend_b_q, pend_b_d;
   logic       led_en_q, led_en_d;
   logic [7:0] err_count_q, err_count_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [7:0] pwm_cnt_q, pwm_cnt_d;
   logic       tick;
   logic       wrap;
   logic       bad;

   assign bad = frame_bad(cmd_q, len_q, r_q, g_q, b_q, chk_q);

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (frame_valid) state_d = ST_CHECK;
         ST_CHECK:  state_d = bad ? ST_REJECT : ST_APPLY;
         ST_APPLY:  state_d = ST_IDLE;
         ST_REJECT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      frame_ok  = (state_q == ST_APPLY);
      frame_err = (state_q == ST_REJECT);
   end

   assign state     = state_q;
   assign err_count = err_count_q;

   // Datapath: shadow bytes, pending duties, enable, error count, PWM timebase
   always_comb begin
      cmd_d       = cmd_q;
      len_d       = len_q;
      r_d         = r_q;
      g_d         = g_q;
      b_d         = b_q;
      chk_d       = chk_q;
      pend_r_d    = pend_r_q;
      pend_g_d    = pend_g_q;
      pend_b_d    = pend_b_q;
      led_en_d    = led_en_q;
      err_count_d = err_count_q;

      if ((state_q == ST_IDLE) && frame_valid) begin
         cmd_d = cmd_in;
         len_d = length_in;
         r_d   = r_in;
         g_d   = g_in;
         b_d   = b_in;
         chk_d = check_in;
      end

      if (state_q == ST_APPLY) begin
         if (cmd_q == CMD_SET) begin
            led_en_d = 1'b1;
            pend_r_d = r_q;
            if (len_q >= 8'd2)    pend_g_d = g_q;
            if (len_q == MAX_LEN) pend_b_d = b_q;
         end else if (cmd_q == CMD_OFF) begin
            led_en_d = 1'b0;
         end
      end

      if ((state_q == ST_REJECT) && (err_count_q != 8'hFF))
         err_count_d = err_count_q + 8'd1;
   end

   assign tick = (pre_q == PRE_LAST);
   assign wrap = tick && (pwm_cnt_q == 8'hFF);

   always_comb begin
      pre_d     = tick ? '0 : pre_q + PW'(1);
      pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cmd_q       <= 8'd0;
         len_q       <= 8'd0;
         r_q         <= 8'd0;
         g_q         <= 8'd0;
         b_q         <= 8'd0;
         chk_q       <= 8'd0;
         pend_r_q    <= 8'd0;
         pend_g_q    <= 8'd0;
         pend_b_q    <= 8'd0;
         led_en_q    <= 1'b0;
         err_count_q <= 8'd0;
         pre_q       <= '0;
         pwm_cnt_q   <= 8'd0;
      end else begin
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         r_q         <= r_d;
         g_q         <= g_d;
         b_q         <= b_d;
         chk_q       <= chk_d;
         pend_r_q    <= pend_r_d;
         pend_g_q    <= pend_g_d;
         pend_b_q    <= pend_b_d;
         led_en_q    <= led_en_d;
         err_count_q <= err_count_d;
         pre_q       <= pre_d;
         pwm_cnt_q   <= pwm_cnt_d;
      end
   end

   // Channels see the registered pend_*, so an APPLY landing on the wrap
   // cycle loads the previous value and the new one waits a full period.
   rgb_pwm_channel #(.INVERT_OUT(INVERT_OUT)) u_ch_r (
      .clk(clk), .reset(reset), .pend(pend_r_q), .load(wrap),
      .cnt(pwm_cnt_q), .en(led_en_q), .pwm(pwm_r)
   );

   rgb_pwm_channel #(.INVERT_OUT(INVERT_OUT)) u_ch_g (
      .clk(clk), .reset(reset), .pend(pend_g_q), .load(wrap),
      .cnt(pwm_cnt_q), .en(led_en_q), .pwm(pwm_g)
   );

   rgb_pwm_channel #(.INVERT_OUT(INVERT_OUT)) u_ch_b (
      .clk(clk), .reset(reset), .pend(pend_b_q), .load(wrap),
      .cnt(pwm_cnt_q), .en(led_en_q), .pwm(pwm_b)
   );

endmodule
